// File: rtl/sprite_blitter.sv
// Pixel engine: expands one draw/erase/fill command into a registered (x, y, color, plot) stream.
// Define BLIT_CLIP_EN to suppress plots that fall outside the SCR_W x SCR_H screen.
module sprite_blitter #(
  parameter int unsigned SCR_W    = 160,
  parameter int unsigned SCR_H    = 120,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned SPR_W    = 7,
  parameter int unsigned SPR_H    = 7,
  parameter int unsigned FRAMES   = 2,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned BG_COLOR = 0,
  parameter int unsigned FRAME_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [FRAME_W-1:0] frame,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [X_W-1:0]     rect_w,
  input  logic [Y_W-1:0]     rect_h,
  input  logic [COLOR_W-1:0] fg_color,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [SPR_W-1:0]   rom_data,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               busy,
  output logic               done
);

`ifdef BLIT_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif

  localparam logic [X_W:0]       ScrWL   = (X_W+1)'(SCR_W);
  localparam logic [Y_W:0]       ScrHL   = (Y_W+1)'(SCR_H);
  localparam logic [X_W-1:0]     ColLast = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0]     RowLast = Y_W'(SPR_H - 1);
  localparam logic [COLOR_W-1:0] BgCol   = COLOR_W'(BG_COLOR);

  typedef enum logic [2:0] {StIdle, StFetch, StScan, StFill, StDone} state_e;

  state_e             state_q;
  logic               erase_q;
  logic [X_W-1:0]     x0_q, w_q, col_q, x_q;
  logic [Y_W-1:0]     y0_q, h_q, row_q, y_q;
  logic [COLOR_W-1:0] fg_q, color_q;
  logic [SPR_W-1:0]   bits_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic               plot_q, busy_q, done_q;

  // Coordinates of the pixel that will be presented in the next cycle.
  logic [X_W-1:0]   org_x, pix_col;
  logic [Y_W-1:0]   org_y, pix_row;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;
  logic [SPR_W-1:0] bits_shift;
  logic             clip_ok, fill_col_end;

  always_comb begin
    org_x        = x0_q;
    org_y        = y0_q;
    pix_col      = '0;
    pix_row      = row_q;
    fill_col_end = (col_q == (w_q - X_W'(1)));
    unique case (state_q)
      StIdle: begin
        org_x   = x_in;
        org_y   = y_in;
        pix_row = '0;
      end
      StScan: pix_col = col_q + X_W'(1);
      StFill: begin
        if (fill_col_end) pix_row = row_q + Y_W'(1);
        else              pix_col = col_q + X_W'(1);
      end
      default: ;
    endcase
    // One extra bit keeps the unwrapped sum for the clip test.
    sum_x      = {1'b0, org_x} + {1'b0, pix_col};
    sum_y      = {1'b0, org_y} + {1'b0, pix_row};
    clip_ok    = !ClipEn || ((sum_x < ScrWL) && (sum_y < ScrHL));
    bits_shift = bits_q >> pix_col;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      erase_q    <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      fg_q       <= '0;
      bits_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x0_q    <= x_in;
            y0_q    <= y_in;
            w_q     <= rect_w;
            h_q     <= rect_h;
            fg_q    <= fg_color;
            erase_q <= (mode == 2'b01);
            col_q   <= '0;
            row_q   <= '0;
            if (!mode[1]) begin
              state_q    <= StFetch;
              busy_q     <= 1'b1;
              rom_addr_q <= ADDR_W'(frame * SPR_H);
            end else if ((rect_w == '0) || (rect_h == '0)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              // First fill pixel is already on the outputs in the cycle after start.
              state_q <= StFill;
              busy_q  <= 1'b1;
              x_q     <= sum_x[X_W-1:0];
              y_q     <= sum_y[Y_W-1:0];
              color_q <= fg_color;
              plot_q  <= clip_ok;
            end
          end
        end
        StFetch: begin
          state_q <= StScan;
          bits_q  <= rom_data;
          col_q   <= '0;
          x_q     <= sum_x[X_W-1:0];
          y_q     <= sum_y[Y_W-1:0];
          color_q <= erase_q ? BgCol : fg_q;
          plot_q  <= rom_data[0] & clip_ok;
        end
        StScan: begin
          if (col_q == ColLast) begin
            plot_q <= 1'b0;
            if (row_q == RowLast) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StFetch;
              row_q      <= row_q + Y_W'(1);
              rom_addr_q <= rom_addr_q + ADDR_W'(1);
            end
          end else begin
            col_q  <= pix_col;
            x_q    <= sum_x[X_W-1:0];
            y_q    <= sum_y[Y_W-1:0];
            plot_q <= bits_shift[0] & clip_ok;
          end
        end
        StFill: begin
          if (fill_col_end && (row_q == (h_q - Y_W'(1)))) begin
            state_q <= StDone;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            col_q  <= pix_col;
            row_q  <= pix_row;
            x_q    <= sum_x[X_W-1:0];
            y_q    <= sum_y[Y_W-1:0];
            plot_q <= clip_ok;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign x        = x_q;
  assign y        = y_q;
  assign color    = color_q;
  assign plot     = plot_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: expected pixels are queued per command and popped on each plot.
module tb_sprite_blitter;

`ifdef BLIT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset_n, start;
  logic [1:0] mode;
  logic       frame;
  logic [7:0] x_in, rect_w, x;
  logic [6:0] y_in, rect_h, y;
  logic [2:0] fg_color, color;
  logic [3:0] rom_addr;
  logic [6:0] rom_data;
  logic       plot, busy, done;

  logic [6:0] rom [0:15];
  assign rom_data = rom[rom_addr];

  pix_t exp_q[$];
  pix_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  sprite_blitter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .frame    (frame),
    .x_in     (x_in),
    .y_in     (y_in),
    .rect_w   (rect_w),
    .rect_h   (rect_h),
    .fg_color (fg_color),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .x        (x),
    .y        (y),
    .color    (color),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every plot must match the head of the expected queue.
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      check("plot_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("pixel", {14'd0, x, y, color}, {14'd0, mon_e});
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic push_pix(input int xu, input int yu, input logic [2:0] c);
    pix_t p;
    if (!CLIP || (xu < 160 && yu < 120)) begin
      p.px = 8'(xu);
      p.py = 7'(yu);
      p.pc = c;
      exp_q.push_back(p);
    end
  endtask

  task automatic queue_sprite(input int fr, input int x0, input int y0, input logic [2:0] c);
    for (int r = 0; r < 7; r++)
      for (int cl = 0; cl < 7; cl++)
        if (rom[fr*7 + r][cl]) push_pix(x0 + cl, y0 + r, c);
  endtask

  task automatic queue_fill(input int x0, input int y0, input int w, input int h,
                            input logic [2:0] c);
    for (int r = 0; r < h; r++)
      for (int cl = 0; cl < w; cl++) push_pix(x0 + cl, y0 + r, c);
  endtask

  task automatic rom_all(input logic [6:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic set_cmd(input logic [1:0] m, input logic f, input int x0, input int y0,
                         input int w, input int h, input logic [2:0] c);
    mode = m; frame = f; x_in = 8'(x0); y_in = 7'(y0);
    rect_w = 8'(w); rect_h = 7'(h); fg_color = c;
  endtask

  // Pulses start; lat counts cycles after the sampling edge until done is seen.
  task automatic run_cmd(input int poke, output int lat, output logic b1, output logic bd);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; b1 = 1'b0; bd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) b1 = busy;
      start = 1'b0;
      if (lat == poke) begin
        start = 1'b1; mode = 2'b10; rect_w = 8'd3; rect_h = 7'd3;
      end
      if (done === 1'b1) begin
        bd = busy;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  int   lat, d0;
  logic b1, bd, any_busy;

  initial begin
    reset_n = 1'b0; start = 1'b0;
    set_cmd(2'b00, 1'b0, 0, 0, 0, 0, 3'd0);
    rom_all(7'd0);
    repeat (3) @(negedge clk);
    check("rst_xy", {17'd0, x, y}, 32'd0);
    check("rst_color", {29'd0, color}, 32'd0);
    check("rst_ctrl", {29'd0, plot, busy, done}, 32'd0);
    check("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    reset_n = 1'b1;

    // Single-pixel draw.
    rom[0] = 7'b0001000;
    set_cmd(2'b00, 1'b0, 30, 108, 0, 0, 3'b110);
    queue_sprite(0, 30, 108, 3'b110);
    run_cmd(0, lat, b1, bd);
    check("draw_latency", lat, 57);
    check("draw_busy_first", {31'd0, b1}, 1);
    check("draw_busy_at_done", {31'd0, bd}, 0);
    check("draw_drained", exp_q.size(), 0);

    // Frame 1 select: frame 0 rows all ones would show up if the base were wrong.
    rom_all(7'h7F);
    for (int i = 7; i < 14; i++) rom[i] = 7'd0;
    rom[7] = 7'b1000001;
    set_cmd(2'b00, 1'b1, 100, 50, 0, 0, 3'b011);
    queue_sprite(1, 100, 50, 3'b011);
    run_cmd(0, lat, b1, bd);
    check("frame1_latency", lat, 57);
    check("frame1_drained", exp_q.size(), 0);

    // Erase with a full bitmap: 49 background pixels.
    rom_all(7'h7F);
    set_cmd(2'b01, 1'b0, 30, 108, 0, 0, 3'b111);
    queue_sprite(0, 30, 108, 3'b000);
    check("erase_queued", exp_q.size(), 49);
    run_cmd(0, lat, b1, bd);
    check("erase_latency", lat, 57);
    check("erase_drained", exp_q.size(), 0);

    // Full-width fill.
    set_cmd(2'b10, 1'b0, 0, 35, 160, 4, 3'b101);
    queue_fill(0, 35, 160, 4, 3'b101);
    run_cmd(0, lat, b1, bd);
    check("fill_latency", lat, 641);
    check("fill_busy_first", {31'd0, b1}, 1);
    check("fill_drained", exp_q.size(), 0);

    // Degenerate fills and reserved mode.
    set_cmd(2'b10, 1'b0, 5, 5, 10, 0, 3'b001);
    run_cmd(0, lat, b1, bd);
    check("fill_h0_latency", lat, 1);
    check("fill_h0_busy", {31'd0, b1}, 0);
    set_cmd(2'b11, 1'b0, 5, 5, 0, 3, 3'b001);
    run_cmd(0, lat, b1, bd);
    check("fill_w0_latency", lat, 1);
    set_cmd(2'b11, 1'b0, 7, 9, 3, 2, 3'b010);
    queue_fill(7, 9, 3, 2, 3'b010);
    run_cmd(0, lat, b1, bd);
    check("mode11_latency", lat, 7);
    check("mode11_drained", exp_q.size(), 0);

    // Right-edge sprite, wrapping sprite and corner fill.
    set_cmd(2'b00, 1'b0, 157, 0, 0, 0, 3'b100);
    queue_sprite(0, 157, 0, 3'b100);
    run_cmd(0, lat, b1, bd);
    check("edge_latency", lat, 57);
    check("edge_drained", exp_q.size(), 0);
    set_cmd(2'b00, 1'b0, 253, 60, 0, 0, 3'b010);
    queue_sprite(0, 253, 60, 3'b010);
    run_cmd(0, lat, b1, bd);
    check("wrap_latency", lat, 57);
    check("wrap_drained", exp_q.size(), 0);
    set_cmd(2'b10, 1'b0, 158, 118, 4, 4, 3'b110);
    queue_fill(158, 118, 4, 4, 3'b110);
    run_cmd(0, lat, b1, bd);
    check("corner_latency", lat, 17);
    check("corner_drained", exp_q.size(), 0);

    // start while busy, then start during the done cycle: both ignored.
    rom_all(7'd0);
    rom[0] = 7'b0001000;
    set_cmd(2'b00, 1'b0, 50, 20, 0, 0, 3'b011);
    queue_sprite(0, 50, 20, 3'b011);
    d0 = done_cnt;
    run_cmd(5, lat, b1, bd);
    check("busy_start_latency", lat, 57);
    set_cmd(2'b00, 1'b0, 50, 20, 0, 0, 3'b011);
    queue_sprite(0, 50, 20, 3'b011);
    run_cmd(57, lat, b1, bd);
    check("done_start_latency", lat, 57);
    any_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      any_busy = any_busy | busy;
    end
    check("ignored_no_busy", {31'd0, any_busy}, 0);
    check("ignored_done_count", done_cnt - d0, 2);
    check("ignored_drained", exp_q.size(), 0);

    // Reset during row 3 of a full-bitmap draw.
    rom_all(7'h7F);
    set_cmd(2'b00, 1'b0, 10, 10, 0, 0, 3'b001);
    for (int r = 0; r < 3; r++)
      for (int cl = 0; cl < 7; cl++) push_pix(10 + cl, 10 + r, 3'b001);
    for (int cl = 0; cl < 3; cl++) push_pix(10 + cl, 13, 3'b001);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (28) @(negedge clk);
    reset_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("abort_xy", {17'd0, x, y}, 32'd0);
    check("abort_color", {29'd0, color}, 32'd0);
    check("abort_ctrl", {29'd0, plot, busy, done}, 32'd0);
    check("abort_rom_addr", {28'd0, rom_addr}, 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_drained", exp_q.size(), 0);
    rom_all(7'd0);
    rom[0] = 7'b0000001;
    set_cmd(2'b00, 1'b0, 70, 40, 0, 0, 3'b101);
    queue_sprite(0, 70, 40, 3'b101);
    run_cmd(0, lat, b1, bd);
    check("post_abort_latency", lat, 57);
    check("post_abort_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
